multi_cycle_timer: RTL

//  Synthesisable, parametrised successor to our cycle-counting initial-block threads.
//  NUM_CH independent timers; each counts a programmed number of clk cycles and pulses tick.

---
 rtl/multi_cycle_timer_pkg.sv | 33 +++
 rtl/cycle_timer_ch.sv | 130 +++++++++++++
 rtl/multi_cycle_timer.sv | 98 +++++++++
 3 files changed

// File: rtl/multi_cycle_timer_pkg.sv
// ---------------------------------------------------------------------------
// multi_cycle_timer_pkg
//
// Purpose:
//   Shared types and constants for the multi-channel cycle timer.
//   Holds the per-channel FSM state type and the state encodings.
//
// Contents:
//   ST_IDLE/ST_RUN/ST_DONE : 2-bit state encodings
//   timer_state_t          : per-channel FSM state {IDLE, RUN, DONE}
//   is_last_cycle()        : true when a counter sits on the final cycle of a period
// ---------------------------------------------------------------------------
package multi_cycle_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } timer_state_t;

    // A period of length target covers counts 0 .. target-1, so the last
    // cycle is the one where count equals target-1.  Widths are fixed at the
    // widest counter the block supports; callers zero-extend into it.
    function automatic logic is_last_cycle(input logic [31:0] count,
                                           input logic [31:0] target);
        return (count == (target - 32'd1));
    endfunction

endpackage

// File: rtl/cycle_timer_ch.sv
// ---------------------------------------------------------------------------
// cycle_timer_ch
//
// Purpose:
//   One timer channel.  Counts a programmed number of clk cycles, then
//   pulses tick for one cycle.  One-shot channels park in DONE afterwards;
//   periodic channels start the next period straight away.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous reset, active-high
//   start     in   1      start/restart pulse
//   stop      in   1      abort pulse (wins over start)
//   periodic  in   1      mode, sampled on start: 1=periodic, 0=one-shot
//   load_val  in   CNT_W  period in cycles, sampled on start (0 = do not run)
//   busy      out  1      channel is in RUN
//   tick      out  1      one-cycle pulse at each period end
//   done      out  1      sticky one-shot completion flag
//   count     out  CNT_W  current count within the period
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module cycle_timer_ch
    import multi_cycle_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    timer_state_t     state;
    timer_state_t     state_next;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] target_next;
    logic [CNT_W-1:0] count_next;
    logic             mode_periodic;
    logic             mode_next;
    logic             tick_next;
    logic             busy_next;
    logic             done_next;
    logic             last_cycle;

    assign last_cycle = is_last_cycle(32'(count), 32'(target));

    // Next-state logic.  Priority is stop, then start, then normal counting.
    // A start always zeroes the counter and leaves tick_next at 0, which is
    // what suppresses the tick of an abandoned period on a restart.
    always_comb begin
        state_next  = state;
        count_next  = count;
        target_next = target;
        mode_next   = mode_periodic;
        tick_next   = 1'b0;

        if (stop) begin
            state_next = IDLE;
            count_next = CNT_ZERO;
        end else if (start) begin
            count_next = CNT_ZERO;
            if (load_val != CNT_ZERO) begin
                state_next  = RUN;
                target_next = load_val;
                mode_next   = periodic;
            end else begin
                state_next  = IDLE;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (last_cycle) begin
                        count_next = CNT_ZERO;
                        tick_next  = 1'b1;
                        if (!mode_periodic) begin
                            state_next = DONE;
                        end
                    end else begin
                        count_next = count + CNT_ONE;
                    end
                end
                IDLE: begin
                    state_next = IDLE;
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                    count_next = CNT_ZERO;
                end
            endcase
        end

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // State, counter, latched period/mode and the registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= CNT_ZERO;
            target        <= CNT_ZERO;
            mode_periodic <= 1'b0;
            tick          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            target        <= target_next;
            mode_periodic <= mode_next;
            tick          <= tick_next;
            busy          <= busy_next;
            done          <= done_next;
        end
    end

endmodule

// File: rtl/multi_cycle_timer.sv
// ---------------------------------------------------------------------------
// multi_cycle_timer
//
// Purpose:
//   NUM_CH independent cycle timers, each one-shot or periodic, plus a
//   registered all_done flag that rises once every channel has completed.
//   Used as a timeout/pacing source beside DUTs and as a run-length
//   controller in benches.
//
// Parameters:
//   NUM_CH  number of timer channels (>= 1)
//   CNT_W   counter/period width; longest period is 2**CNT_W-1 cycles
//
// Ports:
//   clk       in   1             system clock, rising edge
//   rst       in   1             asynchronous reset, active-high
//   start     in   NUM_CH        per-channel start/restart pulse
//   stop      in   NUM_CH        per-channel abort pulse
//   periodic  in   NUM_CH        per-channel mode, sampled on start
//   load_val  in   NUM_CH*CNT_W  per-channel period, ch i at [i*CNT_W +: CNT_W]
//   busy      out  NUM_CH        channel in RUN
//   tick      out  NUM_CH        one-cycle pulse at each period end
//   done      out  NUM_CH        sticky one-shot completion
//   count     out  NUM_CH*CNT_W  current count per channel
//   all_done  out  1             registered AND of done[]
//
// Configuration:
//   TIMER_TRACE_EN  when defined, adds simulation-only trace prints of each
//                   tick and of all_done rising.  Hardware is unchanged.
// ---------------------------------------------------------------------------
module multi_cycle_timer
    import multi_cycle_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic                    all_done
);

    // One channel per slice of the packed load/count buses.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cycle_timer_ch #(
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .stop     (stop[g]),
            .periodic (periodic[g]),
            .load_val (load_val[g*CNT_W +: CNT_W]),
            .busy     (busy[g]),
            .tick     (tick[g]),
            .done     (done[g]),
            .count    (count[g*CNT_W +: CNT_W])
        );
    end

    // all_done follows done[] one cycle later.  Periodic channels never set
    // done, so any periodic channel keeps this low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_done <= 1'b0;
        end else begin
            all_done <= &done;
        end
    end

`ifdef TIMER_TRACE_EN
    // Simulation-only trace.  The all_done line fires on the edge where the
    // flag is about to rise, so it prints exactly once per rise.
    for (genvar t = 0; t < NUM_CH; t++) begin : g_trace
        always @(posedge clk) begin
            if (!rst && tick[t]) begin
                $display("[%0d] tick time : %t", t, $time);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && (&done) && !all_done) begin
            $display("[all] all_done time : %t", $time);
        end
    end
`else
    // Trace disabled: no display code is compiled.
`endif

endmodule
